pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central sequencer for the 5-stage IF/ID/EX/MEM/WB pipeline. Produces per-stage
//  enables (hold) and flushes (bubble) from load-use hazards, EX branch/jump
//  redirects and data-memory wait handshakes. Runs a wait watchdog that halts the
//  core on a hung dmem. Sits beside the stage chain; every pipeline register obeys it.
// PARAMETERS
//  REG_ADDR_W   5    register index width
//  MEM_TIMEOUT  256  max consecutive dmem wait cycles before ERROR (>=2)
//  CNT_WIDTH    32   perf counter width
// PORTS
//  clk           in   1           core clock
//  arst_n        in   1           async active-low reset
//  id_rs1        in   REG_ADDR_W  rs1 of instr in ID
//  id_rs2        in   REG_ADDR_W  rs2 of instr in ID
//  id_rs1_used   in   1           ID instr reads rs1
//  id_rs2_used   in   1           ID instr reads rs2
//  ex_valid      in   1           EX holds a real instr (not bubble)
//  ex_is_load    in   1           EX instr is a load
//  ex_rd         in   REG_ADDR_W  EX destination reg
//  ex_redirect   in   1           EX resolved taken branch/jump
//  mem_req       in   1           MEM stage issuing dmem access this cycle
//  mem_ready     in   1           dmem completes access this cycle
//  if_en,id_en   out  1 each      IF (PC) / IF-ID register load enable
//  ex_en,mem_en  out  1 each      ID-EX / EX-MEM register load enable
//  wb_en_stage   out  1           MEM-WB register load enable
//  id_flush      out  1           load bubble into IF-ID at next edge
//  ex_flush      out  1           load bubble into ID-EX at next edge
//  wb_flush      out  1           load bubble into MEM-WB at next edge
//  halted        out  1           core halted (ERROR state)
//  stall_cycles  out  CNT_WIDTH   perf: cycles with if_en=0
//  flush_events  out  CNT_WIDTH   perf: redirects taken
// BEHAVIOUR
//  FSM states: RESET, RUN, MEM_WAIT, ERROR. Reset (async) -> RESET, wait_cnt=0,
//   counters=0. Outputs are combinational from state+inputs.
//  RESET: all *_en=0, all flushes=1, halted=0. Next cycle -> RUN unconditionally.
//  freeze = (RUN|MEM_WAIT) & mem_req & !mem_ready.
//  Priority within RUN/MEM_WAIT: freeze > redirect > load-use > normal.
//   freeze: all *_en=0 except wb_en_stage=1 with wb_flush=1; id/ex_flush=0.
//     RUN->MEM_WAIT; in MEM_WAIT wait_cnt++; wait_cnt==MEM_TIMEOUT-1 & still
//     freeze -> ERROR. Redirect/load-use held off (EX frozen, inputs persist).
//   redirect (ex_redirect&ex_valid): all en=1, id_flush=1, ex_flush=1 (2-cycle
//     penalty); flush_events++.
//   load-use: ex_valid & ex_is_load & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) |
//     (id_rs2_used & id_rs2==ex_rd)): if_en=id_en=0, ex_flush=1, ex/mem/wb en=1.
//     Exactly one stall cycle (load advances to MEM, hazard clears).
//   normal: all en=1, all flushes=0.
//  MEM_WAIT & mem_ready -> RUN same cycle logic as RUN, wait_cnt cleared.
//  wait_cnt cleared on every exit from MEM_WAIT; single-cycle hit never enters it.
//  ERROR: all en=0, flushes=0, halted=1; sticky until arst_n.
//  x0 never creates a hazard. Reset mid-stall/mid-wait abandons it; RESET re-flushes.
// CONFIGURATION
//  PIPE_HAZARD_CTRL_PERF_EN defined: stall_cycles increments each cycle if_en=0
//   (excluding RESET/ERROR); flush_events per redirect; both saturate at all-ones.
//  Undefined: counters not built; stall_cycles, flush_events tied to 0.
// TESTING
//  1 release reset -> one cycle all flush=1/en=0, then all en=1, flush=0.
//  2 ex_is_load, ex_rd=5, id_rs2=5 used -> 1 cycle if_en=id_en=0, ex_flush=1; ex_rd=0 -> no stall.
//  3 ex_redirect=1 -> id_flush=ex_flush=1 one cycle, flush_events 0->1 (PERF_EN).
//  4 mem_req=1, mem_ready=0 for 3 cycles, plus ex_redirect -> all frozen, wb_flush=1,
//    no id_flush; cycle 4 mem_ready=1 -> redirect flush fires, state RUN.
//  5 MEM_TIMEOUT=4, mem_ready held 0 -> ERROR after 4 wait cycles, halted=1 until arst_n.
//  6 arst_n pulsed during MEM_WAIT -> RESET, wait_cnt=0, counters=0, halted=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-stage enables/flushes for the 5-stage pipeline (load-use, redirect, dmem wait) plus dmem watchdog.
// Latency: all controls are combinational from state + inputs; state/counters update at the next core edge.
// Backpressure: a dmem wait freezes IF..MEM and bubbles MEM-WB; define PIPE_HAZARD_CTRL_PERF_EN to build perf counters.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_redirect,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  if_en,
  output logic                  id_en,
  output logic                  ex_en,
  output logic                  mem_en,
  output logic                  wb_en_stage,
  output logic                  id_flush,
  output logic                  ex_flush,
  output logic                  wb_flush,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic [CNT_WIDTH-1:0]  flush_events
);

  // Wait counter only has to reach MEM_TIMEOUT-1 before the watchdog trips.
  localparam int WCW = $clog2(MEM_TIMEOUT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_RUN,
    ST_MEM_WAIT,
    ST_ERROR
  } state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

  logic active;
  logic freeze;
  logic redirect;
  logic load_use;

  // Hazard detection; x0 is never a real producer so it never stalls.
  assign active   = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
  assign freeze   = active && mem_req && !mem_ready;
  assign redirect = ex_redirect && ex_valid;
  assign load_use = ex_valid && ex_is_load && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  // Next-state and stage controls; priority freeze > redirect > load-use > normal.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    if_en       = 1'b0;
    id_en       = 1'b0;
    ex_en       = 1'b0;
    mem_en      = 1'b0;
    wb_en_stage = 1'b0;
    id_flush    = 1'b0;
    ex_flush    = 1'b0;
    wb_flush    = 1'b0;
    halted      = 1'b0;
    case (state_q)
      ST_RESET: begin
        id_flush   = 1'b1;
        ex_flush   = 1'b1;
        wb_flush   = 1'b1;
        wait_cnt_d = '0;
        state_d    = ST_RUN;
      end
      ST_RUN, ST_MEM_WAIT: begin
        if (freeze) begin
          // Only the MEM-WB register moves, and it takes a bubble while MEM waits.
          wb_en_stage = 1'b1;
          wb_flush    = 1'b1;
          if (state_q == ST_RUN) begin
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = '0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_d    = ST_ERROR;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else begin
          state_d     = ST_RUN;
          wait_cnt_d  = '0;
          ex_en       = 1'b1;
          mem_en      = 1'b1;
          wb_en_stage = 1'b1;
          if (redirect) begin
            // Squash the two younger instructions fetched down the wrong path.
            if_en    = 1'b1;
            id_en    = 1'b1;
            id_flush = 1'b1;
            ex_flush = 1'b1;
          end else if (load_use) begin
            // Hold IF/ID one cycle; the load moves to MEM and a bubble enters EX.
            ex_flush = 1'b1;
          end else begin
            if_en = 1'b1;
            id_en = 1'b1;
          end
        end
      end
      ST_ERROR: begin
        halted = 1'b1;
      end
      default: begin
        state_d    = ST_RESET;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Controller state and dmem wait counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_RESET;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic                 stall_evt;
  logic                 redirect_evt;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  // Stalls count only while the core is live; a redirect counts only when it is taken.
  assign stall_evt    = active && !if_en;
  assign redirect_evt = active && !freeze && redirect;

  // Saturating perf counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (redirect_evt && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
// Expected control vectors are queued as stimulus is driven and popped at the following negedge.
// Perf counters are modelled from the queued expectations; zero when the perf macro is undefined.
module tb_pipe_hazard_ctrl;

  localparam int AW = 5;
  localparam int CW = 32;

  // {if_en,id_en,ex_en,mem_en,wb_en_stage, id_flush,ex_flush,wb_flush, halted}
  localparam logic [8:0] O_RESET  = 9'b00000_111_0;
  localparam logic [8:0] O_NORM   = 9'b11111_000_0;
  localparam logic [8:0] O_LU     = 9'b00111_010_0;
  localparam logic [8:0] O_REDIR  = 9'b11111_110_0;
  localparam logic [8:0] O_FREEZE = 9'b00001_001_0;
  localparam logic [8:0] O_ERROR  = 9'b00000_000_1;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_rs1_used = 1'b0, id_rs2_used = 1'b0, ex_valid = 1'b0;
  logic          ex_is_load = 1'b0, ex_redirect = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic          if_en, id_en, ex_en, mem_en, wb_en_stage;
  logic          id_flush, ex_flush, wb_flush, halted;
  logic [CW-1:0] stall_cycles, flush_events;

  logic [8:0] exp_q[$];
  logic [8:0] last_exp = O_RESET;
  logic [8:0] got, e;
  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  pipe_hazard_ctrl #(.REG_ADDR_W(AW), .MEM_TIMEOUT(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .arst_n(arst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en_stage(wb_en_stage),
    .id_flush(id_flush), .ex_flush(ex_flush), .wb_flush(wb_flush), .halted(halted),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {if_en, id_en, ex_en, mem_en, wb_en_stage, id_flush, ex_flush, wb_flush, halted};
  endfunction

  // Drive one cycle of inputs (called just after a posedge), queue the expectation, wait to the sample point.
  task automatic drive(input int rs1, input int rs2, input int u1, input int u2,
                       input int exv, input int ld, input int rd, input int redir,
                       input int req, input int rdy, input logic [8:0] ex);
    id_rs1      = AW'(rs1);
    id_rs2      = AW'(rs2);
    id_rs1_used = (u1 != 0);
    id_rs2_used = (u2 != 0);
    ex_valid    = (exv != 0);
    ex_is_load  = (ld != 0);
    ex_rd       = AW'(rd);
    ex_redirect = (redir != 0);
    mem_req     = (req != 0);
    mem_ready   = (rdy != 0);
    exp_q.push_back(ex);
    last_exp = ex;
    @(negedge clk);
  endtask

  // Cross the next edge and update the perf model from the cycle just checked.
  task automatic advance();
    @(posedge clk);
    #1;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    if (last_exp != O_RESET && last_exp != O_ERROR && !last_exp[8]) exp_stall++;
    if (last_exp == O_REDIR) exp_flush++;
`endif
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    arst_n = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    last_exp = O_RESET;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RESET);
    got = outs(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL reset_held got %b expected %b", got, e); end
    checks++;
    if (stall_cycles !== '0 || flush_events !== '0 || halted !== 1'b0) begin
      errors++; $display("FAIL reset_counters got stall=%0d flush=%0d halted=%b expected 0 0 0", stall_cycles, flush_events, halted);
    end
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, (i == 0) ? O_RESET : O_NORM);
      got = outs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset_release step %0d got %b expected %b", i, got, e); end
      advance();
    end
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: drive(1, 5, 0, 1, 1, 1, 5, 0, 0, 0, O_LU);    // rs2 matches load rd
        1: drive(1, 5, 0, 1, 0, 0, 5, 0, 0, 0, O_NORM);  // bubble in EX, load gone
        2: drive(0, 0, 1, 1, 1, 1, 0, 0, 0, 0, O_NORM);  // x0 never hazards
        3: drive(7, 2, 1, 0, 1, 1, 7, 0, 0, 0, O_LU);    // rs1 matches
        4: drive(7, 2, 0, 0, 1, 1, 7, 0, 0, 0, O_NORM);  // rs1 not used
        5: drive(3, 4, 1, 1, 1, 0, 3, 0, 0, 0, O_NORM);  // not a load
        default: drive(9, 9, 1, 1, 0, 1, 9, 0, 0, 0, O_NORM); // EX not valid
      endcase
      got = outs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL load_use step %0d got %b expected %b", i, got, e); end
      advance();
    end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, O_REDIR);
        1: drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_NORM);  // redirect from a bubble ignored
        2: drive(6, 0, 1, 0, 1, 1, 6, 1, 0, 0, O_REDIR); // redirect beats load-use
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM);
      endcase
      got = outs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL redirect step %0d got %b expected %b", i, got, e); end
      advance();
    end
    checks++;
    if (stall_cycles !== CW'(exp_stall) || flush_events !== CW'(exp_flush)) begin
      errors++; $display("FAIL redirect_counters got stall=%0d flush=%0d expected %0d %0d", stall_cycles, flush_events, exp_stall, exp_flush);
    end
  endtask

  task automatic test_freeze();
    for (int i = 0; i < 8; i++) begin
      case (i)
        0, 1, 2: drive(0, 0, 0, 0, 1, 0, 0, 1, 1, 0, O_FREEZE); // redirect held off
        3: drive(0, 0, 0, 0, 1, 0, 0, 1, 1, 1, O_REDIR);        // wait ends, redirect fires
        4: drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NORM);         // single-cycle hit
        5: drive(5, 0, 1, 0, 1, 1, 5, 0, 1, 0, O_FREEZE);       // freeze beats load-use
        6: drive(5, 0, 1, 0, 1, 1, 5, 0, 0, 0, O_LU);           // request dropped, load-use seen
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM);
      endcase
      got = outs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL freeze step %0d got %b expected %b", i, got, e); end
      advance();
    end
    checks++;
    if (stall_cycles !== CW'(exp_stall) || flush_events !== CW'(exp_flush)) begin
      errors++; $display("FAIL freeze_counters got stall=%0d flush=%0d expected %0d %0d", stall_cycles, flush_events, exp_stall, exp_flush);
    end
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FREEZE);
      got = outs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL mid_wait step %0d got %b expected %b", i, got, e); end
      advance();
    end
    test_reset();
  endtask

  task automatic test_timeout();
    // One RUN freeze cycle plus four MEM_WAIT cycles, then ERROR sticks.
    for (int i = 0; i < 9; i++) begin
      if (i < 6) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, (i < 5) ? O_FREEZE : O_ERROR);
      else if (i == 6) drive(0, 0, 0, 0, 1, 0, 0, 1, 1, 1, O_ERROR);
      else drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_ERROR);
      got = outs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL timeout step %0d got %b expected %b", i, got, e); end
      advance();
    end
    checks++;
    if (stall_cycles !== CW'(exp_stall) || flush_events !== CW'(exp_flush)) begin
      errors++; $display("FAIL timeout_counters got stall=%0d flush=%0d expected %0d %0d", stall_cycles, flush_events, exp_stall, exp_flush);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_freeze();
    test_reset_mid_wait();
    test_timeout();
    test_reset();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d entries expected 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
